pipeline_latealu: RTL and testbench

PIPELINE_LATEALU -- requirements
Module: pipeline_latealu

---
 rtl/pipeline_latealu_pkg.sv | 30 +++
 rtl/latealu_mul_iter.sv | 79 +++++++
 rtl/pipeline_latealu.sv | 149 ++++++++++++++
 tb/tb_pipeline_latealu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_latealu_pkg.sv
// Shared constants for the late ALU: op codes, CP0 register indices,
// exception codes, multiply latency, and CP0 read-word formatting helpers.
package pipeline_latealu_pkg;

    localparam logic [5:0] OP_MULT    = 6'b000100;
    localparam logic [5:0] OP_MTHI    = 6'b000101;
    localparam logic [5:0] OP_MTLO    = 6'b000110;
    localparam logic [5:0] OP_SYSCALL = 6'b001000;
    localparam logic [5:0] OP_ERET    = 6'b001001;
    localparam logic [5:0] OP_MFC0    = 6'b001010;
    localparam logic [5:0] OP_MTC0    = 6'b001011;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_SYSCALL = 5'd8;

    // Busy cycles per multiply: 32 shift-add iterations plus one sign fixup.
    localparam int unsigned MULT_CYCLES = 33;

    function automatic logic [31:0] cause_word(input logic [1:0] ip, input logic [4:0] code);
        return {22'b0, ip, 1'b0, code, 2'b0};
    endfunction

    function automatic logic [31:0] status_word(input logic exl);
        return {30'b0, exl, 1'b0};
    endfunction

endpackage

// File: rtl/latealu_mul_iter.sv
// Iterative signed 32x32 multiplier: shift-add on operand magnitudes, then a
// single cycle that applies the result sign. done is high during that last cycle.
module latealu_mul_iter
    import pipeline_latealu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ITER  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;

    localparam logic [4:0] LAST_ITER = 5'(MULT_CYCLES - 2);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic [32:0] partial;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        // Upper half plus multiplicand when the current multiplier bit is set.
        partial = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ITER;
                    cnt_d   = 5'd0;
                    mcand_d = op_a[31] ? -op_a : op_a;
                    acc_d   = {32'b0, (op_b[31] ? -op_b : op_b)};
                    neg_d   = op_a[31] ^ op_b[31];
                end
            end
            ST_ITER: begin
                acc_d = {partial, acc_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIXUP;
                end
            end
            ST_FIXUP: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            mcand_q <= 32'd0;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_FIXUP);
    assign product = neg_q ? -acc_q : acc_q;

endmodule

// File: rtl/pipeline_latealu.sv
// Late-stage ALU: HI/LO with an iterative multiplier, plus the CP0 subset
// (Status.EXL, Cause, EPC) for syscall/eret/mfc0/mtc0 and external exceptions.
module pipeline_latealu
    import pipeline_latealu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        latealu_enable,
    input  logic [5:0]  latealu_op,
    input  logic [31:0] latealu_a0,
    input  logic [31:0] latealu_a1,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    output logic        latealu_ready,
    output logic [31:0] latealu_mult_hi,
    output logic [31:0] latealu_mult_lo,
    output logic [31:0] latealu_cpr14,
    output logic [31:0] cp0_rdata,
    output logic        cp0_rdata_valid,
    output logic        exl,
    output logic        protocol_error
);

    logic [31:0] hi_q, hi_d, lo_q, lo_d, epc_q, epc_d, rdata_q, rdata_d;
    logic [1:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic        exl_q, exl_d, rvalid_q, rvalid_d, perr_q, perr_d;
    logic        accept, mul_start, mul_busy, mul_done;
    logic [63:0] mul_product;
    logic [4:0]  cp0_idx;
    logic [31:0] cp0_read;

    assign latealu_ready = !mul_busy;
    assign accept        = latealu_enable && latealu_ready;
    assign mul_start     = accept && (latealu_op == OP_MULT);
    assign cp0_idx       = latealu_a0[4:0];

    latealu_mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op_a    (latealu_a0),
        .op_b    (latealu_a1),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        case (cp0_idx)
            CP0_STATUS: cp0_read = status_word(exl_q);
            CP0_CAUSE:  cp0_read = cause_word(ip_q, code_q);
            CP0_EPC:    cp0_read = epc_q;
            default:    cp0_read = 32'd0;
        endcase
    end

    always_comb begin
        hi_d     = hi_q;
        lo_d     = lo_q;
        epc_d    = epc_q;
        ip_d     = ip_q;
        code_d   = code_q;
        exl_d    = exl_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        perr_d   = perr_q;
        if (latealu_enable && !latealu_ready) begin
            perr_d = 1'b1;
        end
        if (mul_done) begin
            {hi_d, lo_d} = mul_product;
        end
        if (accept) begin
            // CP0 writes from the op stream yield to a same-cycle exception.
            case (latealu_op)
                OP_MULT: ;
                OP_MTHI: hi_d = latealu_a0;
                OP_MTLO: lo_d = latealu_a0;
                OP_MFC0: begin
                    rvalid_d = 1'b1;
                    rdata_d  = cp0_read;
                end
                OP_MTC0: begin
                    if (!exc_req) begin
                        case (cp0_idx)
                            CP0_STATUS: exl_d = latealu_a1[1];
                            CP0_CAUSE:  ip_d  = latealu_a1[9:8];
                            CP0_EPC:    epc_d = latealu_a1;
                            default:    ;
                        endcase
                    end
                end
                OP_SYSCALL: begin
                    if (!exc_req) begin
                        epc_d  = latealu_a0;
                        code_d = EXC_SYSCALL;
                        exl_d  = 1'b1;
                    end
                end
                OP_ERET: begin
                    if (!exc_req) begin
                        exl_d = 1'b0;
                    end
                end
                default: perr_d = 1'b1;
            endcase
        end
        if (exc_req) begin
            epc_d  = exc_pc;
            code_d = exc_code;
            exl_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            epc_q    <= 32'd0;
            ip_q     <= 2'd0;
            code_q   <= 5'd0;
            exl_q    <= 1'b0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            epc_q    <= epc_d;
            ip_q     <= ip_d;
            code_q   <= code_d;
            exl_q    <= exl_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            perr_q   <= perr_d;
        end
    end

    assign latealu_mult_hi = hi_q;
    assign latealu_mult_lo = lo_q;
    assign latealu_cpr14   = epc_q;
    assign cp0_rdata       = rdata_q;
    assign cp0_rdata_valid = rvalid_q;
    assign exl             = exl_q;
    assign protocol_error  = perr_q;

endmodule

// File: tb/tb_pipeline_latealu.sv
// Bench for pipeline_latealu: directed scenarios plus randomized traffic,
// checked every cycle against a cycle-count-level behavioural model.
module tb_pipeline_latealu;

    logic        clk = 1'b0;
    logic        rst;
    logic        latealu_enable;
    logic [5:0]  latealu_op;
    logic [31:0] latealu_a0, latealu_a1;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        latealu_ready;
    logic [31:0] latealu_mult_hi, latealu_mult_lo, latealu_cpr14, cp0_rdata;
    logic        cp0_rdata_valid, exl, protocol_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_latealu dut (
        .clk             (clk),
        .rst             (rst),
        .latealu_enable  (latealu_enable),
        .latealu_op      (latealu_op),
        .latealu_a0      (latealu_a0),
        .latealu_a1      (latealu_a1),
        .exc_req         (exc_req),
        .exc_code        (exc_code),
        .exc_pc          (exc_pc),
        .latealu_ready   (latealu_ready),
        .latealu_mult_hi (latealu_mult_hi),
        .latealu_mult_lo (latealu_mult_lo),
        .latealu_cpr14   (latealu_cpr14),
        .cp0_rdata       (cp0_rdata),
        .cp0_rdata_valid (cp0_rdata_valid),
        .exl             (exl),
        .protocol_error  (protocol_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: architectural state plus a busy countdown for mult.
    logic [31:0] m_hi, m_lo, m_epc, m_rdata;
    logic [1:0]  m_ip;
    logic [4:0]  m_code;
    logic        m_exl, m_valid, m_perr;
    logic [63:0] m_pend;
    int          m_busy;

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_epc = 0; m_rdata = 0; m_ip = 0; m_code = 0;
        m_exl = 0; m_valid = 0; m_perr = 0; m_pend = 0; m_busy = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd12) return {30'b0, m_exl, 1'b0};
        if (idx == 5'd13) return {22'b0, m_ip, 1'b0, m_code, 2'b0};
        if (idx == 5'd14) return m_epc;
        return 32'd0;
    endfunction

    task automatic model_edge(input logic en, input logic [5:0] op, input logic [31:0] a0,
                              input logic [31:0] a1, input logic exc, input logic [4:0] code,
                              input logic [31:0] pc);
        logic acc;
        acc = en && (m_busy == 0);
        m_valid = 0;
        if (en && m_busy != 0) m_perr = 1;
        if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0) {m_hi, m_lo} = m_pend;
        end
        if (acc) begin
            case (op)
                6'd4: begin
                    m_pend = $signed({{32{a0[31]}}, a0}) * $signed({{32{a1[31]}}, a1});
                    m_busy = 33;
                end
                6'd5: m_hi = a0;
                6'd6: m_lo = a0;
                6'd10: begin m_rdata = m_read(a0[4:0]); m_valid = 1; end
                6'd11: if (!exc) begin
                    if (a0[4:0] == 5'd12) m_exl = a1[1];
                    if (a0[4:0] == 5'd13) m_ip = a1[9:8];
                    if (a0[4:0] == 5'd14) m_epc = a1;
                end
                6'd8: if (!exc) begin m_epc = a0; m_code = 5'd8; m_exl = 1; end
                6'd9: if (!exc) m_exl = 0;
                default: m_perr = 1;
            endcase
        end
        if (exc) begin m_epc = pc; m_code = code; m_exl = 1; end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ready"}, latealu_ready, m_busy == 0);
        check({tag, ".hi"}, latealu_mult_hi, m_hi);
        check({tag, ".lo"}, latealu_mult_lo, m_lo);
        check({tag, ".epc"}, latealu_cpr14, m_epc);
        check({tag, ".exl"}, exl, m_exl);
        check({tag, ".rvalid"}, cp0_rdata_valid, m_valid);
        check({tag, ".rdata"}, cp0_rdata, m_rdata);
        check({tag, ".perr"}, protocol_error, m_perr);
    endtask

    task automatic step(input string tag, input logic en, input logic [5:0] op,
                        input logic [31:0] a0, input logic [31:0] a1, input logic exc,
                        input logic [4:0] code, input logic [31:0] pc);
        latealu_enable = en; latealu_op = op; latealu_a0 = a0; latealu_a1 = a1;
        exc_req = exc; exc_code = code; exc_pc = pc;
        @(posedge clk);
        model_edge(en, op, a0, a1, exc, code, pc);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 6'd0, 0, 0, 0, 5'd0, 0);
    endtask

    // Runs idle cycles until ready returns; returns how many it took.
    task automatic wait_ready(input string tag, output int n);
        n = 0;
        while (!latealu_ready && n < 40) begin
            step(tag, 0, 6'd0, 0, 0, 0, 5'd0, 0);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [5:0] ops [9] = '{6'd4, 6'd5, 6'd6, 6'd8, 6'd9, 6'd10, 6'd11, 6'h3F, 6'd0};
    logic [4:0] idxs [5] = '{5'd5, 5'd12, 5'd13, 5'd14, 5'd0};

    initial begin
        int n;
        logic [5:0] r_op;
        logic [31:0] r_a0, r_a1;

        rst = 0;
        latealu_enable = 0; latealu_op = 0; latealu_a0 = 0; latealu_a1 = 0;
        exc_req = 0; exc_code = 0; exc_pc = 0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1;

        // mult 3 x -5
        step("mult1", 1, 6'd4, 32'd3, 32'hFFFFFFFB, 0, 5'd0, 0);
        wait_ready("mult1_wait", n);
        check("mult1_latency", n, 33);
        check("mult1_hi", latealu_mult_hi, 32'hFFFFFFFF);
        check("mult1_lo", latealu_mult_lo, 32'hFFFFFFF1);

        // min-int squared, with a request arriving while busy
        step("mult2", 1, 6'd4, 32'h80000000, 32'h80000000, 0, 5'd0, 0);
        step("mult2_busyreq", 1, 6'd5, 32'h12345678, 0, 0, 5'd0, 0);
        wait_ready("mult2_wait", n);
        check("mult2_hi", latealu_mult_hi, 32'h40000000);
        check("mult2_lo", latealu_mult_lo, 32'h00000000);
        check("mult2_perr", protocol_error, 1);

        // syscall, read Cause, eret
        step("syscall", 1, 6'd8, 32'h00400020, 0, 0, 5'd0, 0);
        check("syscall_epc", latealu_cpr14, 32'h00400020);
        check("syscall_exl", exl, 1);
        step("mfc0_cause", 1, 6'd10, 32'd13, 0, 0, 5'd0, 0);
        check("mfc0_cause_val", cp0_rdata, 32'h00000020);
        step("eret", 1, 6'd9, 0, 0, 0, 5'd0, 0);
        check("eret_exl", exl, 0);
        check("eret_valid_drop", cp0_rdata_valid, 0);

        // mtc0 EPC then readback; unimplemented index
        step("mtc0_epc", 1, 6'd11, 32'd14, 32'hBFC00180, 0, 5'd0, 0);
        step("mfc0_epc", 1, 6'd10, 32'd14, 0, 0, 5'd0, 0);
        check("mfc0_epc_val", cp0_rdata, 32'hBFC00180);
        check("mfc0_epc_valid", cp0_rdata_valid, 1);
        step("mfc0_5", 1, 6'd10, 32'd5, 0, 0, 5'd0, 0);
        check("mfc0_5_val", cp0_rdata, 32'd0);
        idle("post_mfc0", 1);

        // exception collides with syscall
        step("exc_sys", 1, 6'd8, 32'h200, 0, 1, 5'd4, 32'h100);
        check("exc_sys_epc", latealu_cpr14, 32'h100);
        step("exc_sys_rd", 1, 6'd10, 32'd13, 0, 0, 5'd0, 0);
        check("exc_sys_code", cp0_rdata[6:2], 5'd4);

        // reset in the middle of a multiply
        step("mult3", 1, 6'd4, 32'd7, 32'd9, 0, 5'd0, 0);
        idle("mult3_iter", 10);
        #3;
        rst = 0;
        #1;
        model_reset();
        compare_all("midreset");
        check("midreset_ready", latealu_ready, 1);
        @(negedge clk);
        rst = 1;
        step("mult4", 1, 6'd4, 32'd7, 32'd9, 0, 5'd0, 0);
        wait_ready("mult4_wait", n);
        check("mult4_latency", n, 33);
        check("mult4_lo", latealu_mult_lo, 32'd63);
        check("mult4_hi", latealu_mult_hi, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r_op = ops[$urandom_range(0, 8)];
            r_a0 = $urandom;
            r_a1 = $urandom;
            if ($urandom_range(0, 1) == 1) r_a0[4:0] = idxs[$urandom_range(0, 4)];
            step("rand", ($urandom_range(0, 1) == 1), r_op, r_a0, r_a1,
                 ($urandom_range(0, 9) == 0), 5'($urandom), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
